// File: rtl/sync_filter_pkg.sv
// sync_filter_pkg
// Shared types and helpers for the sync_filter_regs block.
//   cnt_width()   : width of a per-channel stability counter that must hold
//                   values 0..FILTER_CYCLES.
//   chan_state_t  : per-channel filter state.
package sync_filter_pkg;

  // Counter width able to represent 0..fc inclusive.
  function automatic int cnt_width(input int fc);
    return $clog2(fc + 1);
  endfunction

  typedef enum logic {
    ST_STABLE  = 1'b0,  // synchronized level matches dout, counter idle
    ST_PENDING = 1'b1   // synchronized level differs from dout, counting
  } chan_state_t;

endpackage

// File: rtl/sync_filter_chan.sv
// sync_filter_chan
// One channel of the glitch filter. It takes the already-synchronized level
// and updates dout only after that level has differed from dout for
// FILTER_CYCLES consecutive cycles. On the cycle dout changes, it emits a
// single-cycle rise or fall pulse.
// Optional feature (macro SYNC_FILTER_STICKY_EN): a sticky "seen" flag that
// is set by any edge pulse and cleared by clr_seen. A set in the same cycle
// as a clear takes priority.
// Ports:
//   clk, arst      clock, asynchronous active-high reset
//   s              synchronized input level
//   clr_seen/seen  sticky flag clear / flag (SYNC_FILTER_STICKY_EN only)
//   dout           filtered level
//   rise, fall     registered edge pulses
module sync_filter_chan
  import sync_filter_pkg::*;
#(
  parameter int   FILTER_CYCLES = 4,
  parameter logic RESET_BIT     = 1'b0
) (
  input  logic clk,
  input  logic arst,
  input  logic s,
`ifdef SYNC_FILTER_STICKY_EN
  input  logic clr_seen,
  output logic seen,
`endif
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int            CW   = cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

  chan_state_t   state_r;
  logic [CW-1:0] cnt_r;
  logic          dout_r;
  logic          rise_r;
  logic          fall_r;

  // Filter FSM: count cycles of disagreement, commit the new level on the last one.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_r <= ST_STABLE;
      cnt_r   <= {CW{1'b0}};
      dout_r  <= RESET_BIT;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      case (state_r)
        ST_STABLE, ST_PENDING: begin
          if (s == dout_r) begin
            // Disagreement ended early: the glitch is dropped.
            state_r <= ST_STABLE;
            cnt_r   <= {CW{1'b0}};
          end else if (cnt_r == LAST) begin
            state_r <= ST_STABLE;
            cnt_r   <= {CW{1'b0}};
            dout_r  <= s;
            rise_r  <= s;
            fall_r  <= ~s;
          end else begin
            state_r <= ST_PENDING;
            cnt_r   <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= ST_STABLE;
          cnt_r   <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign dout = dout_r;
  assign rise = rise_r;
  assign fall = fall_r;

`ifdef SYNC_FILTER_STICKY_EN
  logic seen_r;

  // Sticky change flag; an edge in the clearing cycle still gets recorded.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      seen_r <= 1'b0;
    end else if (rise_r | fall_r) begin
      seen_r <= 1'b1;
    end else if (clr_seen) begin
      seen_r <= 1'b0;
    end else begin
      seen_r <= seen_r;
    end
  end

  assign seen = seen_r;
`endif

endmodule

// File: rtl/sync_filter_regs.sv
// sync_filter_regs
// Multi-channel level synchronizer with per-channel glitch filter and edge
// detection. Each din bit goes through a DEPTH-stage flop chain into the clk
// domain. A sync_filter_chan instance per bit then filters the level and
// produces rise/fall pulses.
// Optional feature (macro SYNC_FILTER_STICKY_EN): clr_seen/seen ports with
// per-channel sticky change flags.
// Ports:
//   clk       destination clock
//   arst      asynchronous active-high reset
//   din       asynchronous input levels
//   dout      synchronized, filtered levels
//   rise/fall single-cycle edge pulses of dout
//   clr_seen  sticky flag clear (SYNC_FILTER_STICKY_EN only)
//   seen      sticky change flags (SYNC_FILTER_STICKY_EN only)
module sync_filter_regs
  import sync_filter_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               DEPTH         = 3,
  parameter int               FILTER_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [WIDTH-1:0] din,
`ifdef SYNC_FILTER_STICKY_EN
  input  logic             clr_seen,
  output logic [WIDTH-1:0] seen,
`endif
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // Stage 0 is the metastability-catching flop. Timing constraints treat its
  // D input as a false path. It must not be merged or duplicated.
  (* preserve, dont_replicate *) logic [WIDTH-1:0] meta_r;
  // Stages 1..DEPTH-1. Entry k holds stage k+1.
  logic [WIDTH-1:0] chain_r [DEPTH-1];
  logic [WIDTH-1:0] sync_s;

  // Plain flop chain, no logic between stages.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      meta_r <= RESET_VAL;
      for (int k = 0; k < DEPTH - 1; k++) begin
        chain_r[k] <= RESET_VAL;
      end
    end else begin
      meta_r     <= din;
      chain_r[0] <= meta_r;
      for (int k = 1; k < DEPTH - 1; k++) begin
        chain_r[k] <= chain_r[k-1];
      end
    end
  end

  assign sync_s = chain_r[DEPTH-2];

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sync_filter_chan #(
      .FILTER_CYCLES(FILTER_CYCLES),
      .RESET_BIT    (RESET_VAL[i])
    ) u_chan (
      .clk     (clk),
      .arst    (arst),
      .s       (sync_s[i]),
`ifdef SYNC_FILTER_STICKY_EN
      .clr_seen(clr_seen),
      .seen    (seen[i]),
`endif
      .dout    (dout[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

endmodule

// File: tb/tb_sync_filter_regs.sv
// Directed bench for sync_filter_regs (WIDTH=8, DEPTH=3, FILTER_CYCLES=4,
// RESET_VAL=0). Sticky-flag checks are built only with SYNC_FILTER_STICKY_EN.
module tb_sync_filter_regs;

  logic       clk;
  logic       arst;
  logic [7:0] din;
  logic [7:0] dout;
  logic [7:0] rise;
  logic [7:0] fall;
`ifdef SYNC_FILTER_STICKY_EN
  logic       clr_seen;
  logic [7:0] seen;
`endif

  int checks;
  int errors;

  sync_filter_regs #(
    .WIDTH        (8),
    .DEPTH        (3),
    .FILTER_CYCLES(4),
    .RESET_VAL    (8'h00)
  ) dut (
    .clk     (clk),
    .arst    (arst),
    .din     (din),
`ifdef SYNC_FILTER_STICKY_EN
    .clr_seen(clr_seen),
    .seen    (seen),
`endif
    .dout    (dout),
    .rise    (rise),
    .fall    (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a new level. Then check that dout holds for 6 edges, updates on the
  // 7th edge with the given pulses, and that the pulses drop on the 8th edge.
  task automatic settle(input string tag, input logic [7:0] nv, input logic [7:0] ov,
                        input logic [7:0] er, input logic [7:0] ef);
    din = nv;
    repeat (6) tick();
    chk({tag, "_hold_dout"}, dout, ov);
    chk({tag, "_hold_rise"}, rise, 8'h00);
    chk({tag, "_hold_fall"}, fall, 8'h00);
    tick();
    chk({tag, "_dout"}, dout, nv);
    chk({tag, "_rise"}, rise, er);
    chk({tag, "_fall"}, fall, ef);
    tick();
    chk({tag, "_rise_off"}, rise, 8'h00);
    chk({tag, "_fall_off"}, fall, 8'h00);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    arst   = 1'b1;
    din    = 8'hFF;
`ifdef SYNC_FILTER_STICKY_EN
    clr_seen = 1'b0;
`endif

    // 1. Reset with din=FF, then release: dout=FF on 7th edge (6 after the first).
    tick();
    tick();
    chk("rst_dout", dout, 8'h00);
    chk("rst_rise", rise, 8'h00);
    chk("rst_fall", fall, 8'h00);
`ifdef SYNC_FILTER_STICKY_EN
    chk("rst_seen", seen, 8'h00);
`endif
    arst = 1'b0;
    settle("release", 8'hFF, 8'h00, 8'hFF, 8'h00);

    // Return to a clean zero state.
    arst = 1'b1;
    din  = 8'h00;
    tick();
    arst = 1'b0;
    repeat (8) tick();
    chk("clean_dout", dout, 8'h00);
    chk("clean_fall", fall, 8'h00);

    // 2. Glitch on din[2] lasting 3 cycles: it is filtered out.
    din = 8'h04;
    repeat (3) tick();
    din = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("glitch_dout", dout, 8'h00);
      chk("glitch_rise", rise, 8'h00);
    end

    // 3. Step on din[5].
    settle("step", 8'h20, 8'h00, 8'h20, 8'h00);

    // 4. Mixed: 0F then F0 in one step.
    settle("pre_mixed", 8'h0F, 8'h20, 8'h0F, 8'h20);
    settle("mixed", 8'hF0, 8'h0F, 8'hF0, 8'h0F);

    // 5. Reset two cycles into PENDING.
    din = 8'h00;
    repeat (5) tick();
    arst = 1'b1;
    #1;
    chk("midrst_dout", dout, 8'h00);
    chk("midrst_rise", rise, 8'h00);
    chk("midrst_fall", fall, 8'h00);
    tick();
    tick();
    arst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("postrst_dout", dout, 8'h00);
      chk("postrst_fall", fall, 8'h00);
      chk("postrst_rise", rise, 8'h00);
    end
    settle("restart", 8'h81, 8'h00, 8'h81, 8'h00);

`ifdef SYNC_FILTER_STICKY_EN
    // 6. Sticky flags: a same-cycle set beats clr_seen.
    chk("seen_pre", seen, 8'h81);
    clr_seen = 1'b1;
    tick();
    clr_seen = 1'b0;
    chk("seen_clr", seen, 8'h00);
    din = 8'h83;
    repeat (7) tick();
    chk("seen_rise1", rise, 8'h02);
    clr_seen = 1'b1;
    tick();
    chk("seen_set_wins", seen, 8'h02);
    tick();
    clr_seen = 1'b0;
    chk("seen_cleared", seen, 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
